sub_operand_loader: RTL and testbench

Upstream operand stage for the 16-bit subtractor. It takes a serial stream of words on one valid/ready bus and pairs them in order: first word is the minuend (a), second is the subtrahend (b). Completed pairs are buffered in a small FIFO and presented to the subtractor's a/b inputs with out_valid/out_ready flow control. This decouples the operand source from subtractor back-pressure.

---
 rtl/sub_operand_loader.sv | 128 ++++++++++++
 tb/tb_sub_operand_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sub_operand_loader.sv
// Operand loader for the subtractor: pairs a serial word stream into (minuend, subtrahend)
// and buffers completed pairs in a small FIFO with valid/ready on both sides.
module sub_operand_loader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_a,
    output logic [DATA_W-1:0]          out_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       half_pair
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic {
        S_A = 1'b0,
        S_B = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [DATA_W-1:0]  a_hold;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]  mem_a [DEPTH];
    logic [DATA_W-1:0]  mem_b [DEPTH];

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               latch_a;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    // Wrap bit differs with equal index -> full; identical pointers -> empty.
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    assign out_valid = !empty;
    assign out_a     = out_valid ? mem_a[rd_idx] : DATA_W'(0);
    assign out_b     = out_valid ? mem_b[rd_idx] : DATA_W'(0);
    assign half_pair = (state == S_B);
    assign pop       = out_valid && out_ready && !flush;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, handshake and push/latch strobes; flush kills both strobes.
    always_comb begin
        next_state = state;
        in_ready   = 1'b1;
        push       = 1'b0;
        latch_a    = 1'b0;
        case (state)
            S_A: begin
                if (in_valid) begin
                    latch_a    = 1'b1;
                    next_state = S_B;
                end
            end
            S_B: begin
                in_ready = !full;
                if (in_valid && !full) begin
                    push       = 1'b1;
                    next_state = S_A;
                end
            end
            default: next_state = S_A;
        endcase
        if (flush) begin
            next_state = S_A;
            push       = 1'b0;
            latch_a    = 1'b0;
        end
    end

    // Minuend hold register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_hold <= '0;
        end else if (latch_a) begin
            a_hold <= in_data;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Pair storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_idx] <= a_hold;
            mem_b[wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_sub_operand_loader.sv
// Directed bench for sub_operand_loader; inputs driven and outputs sampled on the falling edge.
module tb_sub_operand_loader;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        half_pair;

    int checks = 0;
    int errors = 0;

    sub_operand_loader #(.DATA_W(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .half_pair (half_pair)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One accepted word: present at a falling edge, transfer on the next rising edge.
    task automatic send(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        check("send_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [15:0] a, input logic [15:0] b);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_a"}, 32'(out_a), 32'(a));
        check({tag, "_b"}, 32'(out_b), 32'(b));
    endtask

    task automatic pop_one(input string tag, input logic [15:0] a, input logic [15:0] b);
        expect_head(tag, a, b);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_data = 16'h0055; in_valid = 1'b1; out_ready = 1'b0;

        // Reset held with in_valid asserted
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_half", 32'(half_pair), 32'd0);
        check("rst_a", 32'(out_a), 32'd0);
        check("rst_b", 32'(out_b), 32'd0);
        rst = 1'b1; in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single pair
        send(16'h000F);
        check("single_half", 32'(half_pair), 32'd1);
        check("single_novalid", 32'(out_valid), 32'd0);
        send(16'h0005);
        expect_head("single", 16'h000F, 16'h0005);
        check("single_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("single_popped", 32'(out_valid), 32'd0);
        check("single_level0", 32'(level), 32'd0);

        // Fill to DEPTH, then back-pressure
        for (int i = 1; i <= 8; i++) send(16'(i));
        check("fill_level", 32'(level), 32'd4);
        check("fill_half0", 32'(half_pair), 32'd0);
        send(16'h0009);
        check("fill_half1", 32'(half_pair), 32'd1);
        in_data = 16'h000A; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_level", 32'(level), 32'd4);
            expect_head("bp_head", 16'h0001, 16'h0002);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_after_pop_level", 32'(level), 32'd3);
        check("bp_after_pop_ready", 32'(in_ready), 32'd1);
        expect_head("bp_new_head", 16'h0003, 16'h0004);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept_level", 32'(level), 32'd4);
        check("bp_accept_half", 32'(half_pair), 32'd0);

        // Drain to level 2, then push and pop in the same cycle
        pop_one("drain0", 16'h0003, 16'h0004);
        pop_one("drain1", 16'h0005, 16'h0006);
        check("pp_level_before", 32'(level), 32'd2);
        send(16'h0011);
        in_data = 16'h0012; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp_level_after", 32'(level), 32'd2);
        pop_one("pp_order0", 16'h0009, 16'h000A);
        pop_one("pp_order1", 16'h0011, 16'h0012);
        check("pp_empty", 32'(out_valid), 32'd0);

        // Wrap-around streaming with out_ready held high
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            send(16'(n));
            check("wrap_level_a", 32'(level), 32'd0);
            send(16'(16'h0100 + n));
            expect_head("wrap", 16'(n), 16'(16'h0100 + n));
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("wrap_empty", 32'(level), 32'd0);

        // Flush with buffered pairs and a held minuend, competing with input and pop
        send(16'h0021); send(16'h0022);
        send(16'h0023); send(16'h0024);
        send(16'h0008);
        check("fl_pre_level", 32'(level), 32'd2);
        check("fl_pre_half", 32'(half_pair), 32'd1);
        flush = 1'b1; in_data = 16'h0077; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("fl_level", 32'(level), 32'd0);
        check("fl_half", 32'(half_pair), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        send(16'h000C);
        check("fl_next_half", 32'(half_pair), 32'd1);
        send(16'h000D);
        expect_head("fl_next", 16'h000C, 16'h000D);

        // Asynchronous reset between clock edges
        send(16'h000E);
        check("ar_pre_half", 32'(half_pair), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_level", 32'(level), 32'd0);
        check("ar_half", 32'(half_pair), 32'd0);
        check("ar_a", 32'(out_a), 32'd0);
        check("ar_b", 32'(out_b), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("ar_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("ar_still_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
